// File: rtl/cache_msg_pkg.sv
// cache_msg_pkg: message field layout, opcode bits, FSM states and field helpers
package cache_msg_pkg;

    localparam int OP_W         = 4;
    localparam int SRC_OFS      = OP_W;
    localparam int OP_BCAST_BIT = 3;
    localparam int OP_LOCK_BIT  = 2;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic logic [3:0] msg_op(input logic [31:0] m);
        return m[3:0];
    endfunction

    function automatic logic [7:0] msg_src(input logic [31:0] m, input int idw);
        return 8'((m >> SRC_OFS) & ((32'd1 << idw) - 32'd1));
    endfunction

    function automatic logic [7:0] msg_dst(input logic [31:0] m, input int idw);
        return 8'((m >> (SRC_OFS + idw)) & ((32'd1 << idw) - 32'd1));
    endfunction

    function automatic logic op_has(input logic [3:0] op, input int b);
        return |(op & (4'd1 << b));
    endfunction

endpackage

// File: rtl/cache_msg_rr_arb.sv
// cache_msg_rr_arb: round-robin picker; search starts one past the last granted port
module cache_msg_rr_arb
    import cache_msg_pkg::*;
#(
    parameter int cache_num = 4,
    localparam int idw = $clog2(cache_num)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [cache_num-1:0] eligible,
    output logic [cache_num-1:0] gnt,
    output logic [idw-1:0]       idx,
    output logic                 valid
);

    logic [idw-1:0] last;
    logic [idw-1:0] p;

    // First eligible port scanning upward from last+1, wrapping modulo cache_num
    always_comb begin
        valid = 1'b0;
        idx = '0;
        p = '0;
        for (int k = 1; k <= cache_num; k++) begin
            p = idw'((int'(last) + k) % cache_num);
            if (!valid && eligible[p]) begin
                valid = 1'b1;
                idx = p;
            end
        end
    end

    assign gnt = valid ? (cache_num'(1) << idx) : '0;

    // Pointer holds the last granted port; reset value makes port 0 the first candidate
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= idw'(cache_num - 1);
        else if (valid)
            last <= idx;
    end

endmodule

// File: rtl/cache_msg_arb.sv
// cache_msg_arb: round-robin coherence message arbiter/router with locked request/response mode.
// Optional per-port saturating grant counters are enabled by defining CACHE_MSG_ARB_STATS_EN.
module cache_msg_arb
    import cache_msg_pkg::*;
#(
    parameter int cache_num    = 4,
    parameter int lock_timeout = 64,
    localparam int idw = $clog2(cache_num),
    localparam int mw  = 4 + 2 * idw
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [cache_num-1:0]    msg_req,
    output logic [cache_num-1:0]    msg_gnt,
    input  logic [cache_num*mw-1:0] msg,
    output logic [cache_num-1:0]    msg_in_valid,
    output logic [mw-1:0]           msg_in,
    output logic                    msg_err,
    output logic                    lock_active,
    output logic                    lock_timeout_o,
    output logic [cache_num*16-1:0] grant_cnt
);

    localparam int tw = ($clog2(lock_timeout) > 0) ? $clog2(lock_timeout) : 1;

    arb_state_t           state;
    logic [idw-1:0]       lock_src;
    logic [idw-1:0]       lock_rsp;
    logic [tw-1:0]        timer;
    logic [cache_num-1:0] eligible;
    logic [cache_num-1:0] gnt;
    logic [idw-1:0]       idx;
    logic                 valid;
    logic [mw-1:0]        sel;
    logic [3:0]           op;
    logic [7:0]           src;
    logic [7:0]           dst;
    logic                 bcast;
    logic                 lock_req;
    logic                 self_dst;
    logic                 release_lock;
    logic                 timeout;
    logic [cache_num-1:0] route;

    // A port granted last cycle still shows req, so it is masked; LOCKED admits only the responder
    assign eligible = msg_req & ~msg_gnt &
                      ((state == LOCKED) ? (cache_num'(1) << lock_rsp) : '1);

    cache_msg_rr_arb #(.cache_num(cache_num)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .gnt      (gnt),
        .idx      (idx),
        .valid    (valid)
    );

    assign sel          = msg[idx*mw +: mw];
    assign op           = msg_op(32'(sel));
    assign src          = msg_src(32'(sel), idw);
    assign dst          = msg_dst(32'(sel), idw);
    assign bcast        = op_has(op, OP_BCAST_BIT);
    assign lock_req     = op_has(op, OP_LOCK_BIT);
    assign self_dst     = dst == src;
    assign route        = bcast ? ~(cache_num'(1) << src) : self_dst ? '0 : (cache_num'(1) << dst);
    assign release_lock = valid && dst == 8'(lock_src);
    assign timeout      = timer == tw'(lock_timeout - 1);

    // Registered grant/delivery outputs and the IDLE/LOCKED lock tracker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            lock_active    <= 1'b0;
            lock_timeout_o <= 1'b0;
            lock_src       <= '0;
            lock_rsp       <= '0;
            timer          <= '0;
            msg_gnt        <= '0;
            msg_in_valid   <= '0;
            msg_in         <= '0;
            msg_err        <= 1'b0;
        end else begin
            msg_gnt        <= gnt;
            msg_in_valid   <= valid ? route : '0;
            msg_err        <= valid && !bcast && self_dst;
            lock_timeout_o <= 1'b0;
            if (valid)
                msg_in <= sel;
            case (state)
                IDLE: begin
                    if (valid && !bcast && lock_req && !self_dst) begin
                        state       <= LOCKED;
                        lock_active <= 1'b1;
                        lock_src    <= idx;
                        lock_rsp    <= dst[idw-1:0];
                        timer       <= '0;
                    end
                end
                LOCKED: begin
                    if (release_lock || timeout) begin
                        state          <= IDLE;
                        lock_active    <= 1'b0;
                        lock_timeout_o <= !release_lock;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_MSG_ARB_STATS_EN
    for (genvar i = 0; i < cache_num; i++) begin : g_cnt
        logic [15:0] cnt;
        // Saturating count of grants issued to this port
        always_ff @(posedge clk) begin
            if (!rst_n)
                cnt <= '0;
            else if (gnt[i] && cnt != 16'hFFFF)
                cnt <= cnt + 16'd1;
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_msg_arb.sv
// tb_cache_msg_arb: directed + randomized scoreboard bench for cache_msg_arb (4 caches, lock_timeout 8)
module tb_cache_msg_arb;

    localparam int N  = 4;
    localparam int LT = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] valid;
        logic [7:0] mi;
        logic       err;
        logic       lock;
        logic       tmo;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic [63:0] c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [7:0]   pm [N];
    logic [N*8-1:0] msg;
    logic [N-1:0] msg_gnt;
    logic [N-1:0] msg_in_valid;
    logic [7:0]   msg_in;
    logic         msg_err;
    logic         lock_active;
    logic         lock_timeout_o;
    logic [N*16-1:0] grant_cnt;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    // reference model state: arbitration pointer, lock bookkeeping, counters
    int         last = N - 1;
    bit         locked = 1'b0;
    int         lsrc = 0;
    int         lrsp = 0;
    int         tmr = 0;
    int         cnt [N];
    logic [3:0] pgnt = '0;
    logic [7:0] mreg = '0;

    always #5 clk = ~clk;

    assign msg = {pm[3], pm[2], pm[1], pm[0]};

    cache_msg_arb #(.cache_num(N), .lock_timeout(LT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .msg_req        (req),
        .msg_gnt        (msg_gnt),
        .msg            (msg),
        .msg_in_valid   (msg_in_valid),
        .msg_in         (msg_in),
        .msg_err        (msg_err),
        .lock_active    (lock_active),
        .lock_timeout_o (lock_timeout_o),
        .grant_cnt      (grant_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Predicts the outputs at the coming clock edge from the inputs now applied
    task automatic model_step();
        obs_t e;
        logic [N-1:0] elig;
        logic [3:0] op;
        logic [63:0] c;
        int w, src, dst;
        bit rel, newlock;
        e = '0;
        if (!rst_n) begin
            last = N - 1;
            locked = 1'b0;
            tmr = 0;
            pgnt = '0;
            mreg = '0;
            foreach (cnt[i]) cnt[i] = 0;
        end else begin
            elig = req & ~pgnt;
            if (locked) elig = elig & (4'b1 << lrsp);
            w = -1;
            for (int k = 1; k <= N && w < 0; k++)
                if (elig[2'((last + k) % N)]) w = (last + k) % N;
            rel = 1'b0;
            newlock = 1'b0;
            dst = 0;
            e.mi = mreg;
            if (w >= 0) begin
                op = pm[w][3:0];
                src = int'(pm[w][5:4]);
                dst = int'(pm[w][7:6]);
                last = w;
                e.gnt = 4'b1 << w;
                e.mi = pm[w];
                if (cnt[w] < 65535) cnt[w]++;
                if (op[3]) e.valid = ~(4'b1 << src);
                else if (dst == src) e.err = 1'b1;
                else e.valid = 4'b1 << dst;
                rel = locked && dst == lsrc;
                newlock = !locked && !op[3] && op[2] && dst != src;
            end
            if (locked) begin
                if (rel) locked = 1'b0;
                else if (tmr == LT - 1) begin
                    locked = 1'b0;
                    e.tmo = 1'b1;
                end else tmr++;
            end else if (newlock) begin
                locked = 1'b1;
                lsrc = w;
                lrsp = dst;
                tmr = 0;
            end
            e.lock = locked;
            pgnt = e.gnt;
            mreg = e.mi;
        end
        c = '0;
`ifdef CACHE_MSG_ARB_STATS_EN
        for (int i = 0; i < N; i++) c[i*16 +: 16] = 16'(cnt[i]);
`endif
        q.push_back('{o: e, c: c});
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] v,
                              input logic [7:0] mi, input logic er, input logic lk, input logic to);
        chk(tag, 64'({msg_gnt, msg_in_valid, msg_in, msg_err, lock_active, lock_timeout_o}),
            64'({g, v, mi, er, lk, to}));
    endtask

    function automatic logic [7:0] rnd_msg(input int i);
        logic [1:0] s;
        s = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'(i);
        return {2'($urandom_range(0, 3)), s, 4'($urandom_range(0, 15))};
    endfunction

    // Monitor: compares every registered output set against the scoreboard entry
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {msg_gnt, msg_in_valid, msg_in, msg_err, lock_active, lock_timeout_o};
                chk("outputs", 64'(a), 64'(e.o));
                chk("grant_cnt", grant_cnt, e.c);
            end
        end
    end

    initial begin
        foreach (pm[i]) pm[i] = '0;
        tick();
        tick();
        expect_out("reset", 4'b0, 4'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // unicast 1 -> 2
        pm[1] = 8'h91;
        req = 4'b0010;
        tick();
        expect_out("t1_unicast", 4'b0010, 4'b0100, 8'h91, 1'b0, 1'b0, 1'b0);
        req = '0;
        tick();
        // broadcast from 0, then a self-addressed unicast from 2
        pm[0] = 8'h08;
        req = 4'b0001;
        tick();
        expect_out("t2_bcast", 4'b0001, 4'b1110, 8'h08, 1'b0, 1'b0, 1'b0);
        pm[2] = 8'hA1;
        req = 4'b0100;
        tick();
        expect_out("t2_self", 4'b0100, 4'b0000, 8'hA1, 1'b1, 1'b0, 1'b0);
        req = '0;
        tick();
        // all four requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) pm[i] = {2'((i + 1) % N), 2'(i), 4'h1};
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_out("t3_rr", 4'b1 << (k % N), 4'b1 << ((k + 1) % N), pm[k % N], 1'b0, 1'b0, 1'b0);
        end
        req = '0;
        tick();
        // lock from 0 to 3, cache 1 blocked until 3 replies
        do_reset();
        pm[0] = 8'hC4;
        pm[1] = 8'h91;
        req = 4'b0011;
        tick();
        expect_out("t4_lock", 4'b0001, 4'b1000, 8'hC4, 1'b0, 1'b1, 1'b0);
        req = 4'b0010;
        tick();
        expect_out("t4_block", 4'b0000, 4'b0000, 8'hC4, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("t4_block", 4'b0000, 4'b0000, 8'hC4, 1'b0, 1'b1, 1'b0);
        pm[3] = 8'h31;
        req = 4'b1010;
        tick();
        expect_out("t4_release", 4'b1000, 4'b0001, 8'h31, 1'b0, 1'b0, 1'b0);
        req = 4'b0010;
        tick();
        expect_out("t4_next", 4'b0010, 4'b0100, 8'h91, 1'b0, 1'b0, 1'b0);
        req = '0;
        tick();
        // lock timeout with a silent responder
        do_reset();
        req = 4'b0001;
        tick();
        expect_out("t5_lock", 4'b0001, 4'b1000, 8'hC4, 1'b0, 1'b1, 1'b0);
        req = 4'b0010;
        for (int k = 0; k < LT - 1; k++) begin
            tick();
            expect_out("t5_wait", 4'b0000, 4'b0000, 8'hC4, 1'b0, 1'b1, 1'b0);
        end
        tick();
        expect_out("t5_timeout", 4'b0000, 4'b0000, 8'hC4, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("t5_after", 4'b0010, 4'b0100, 8'h91, 1'b0, 1'b0, 1'b0);
        req = '0;
        tick();
        // reset while LOCKED with requests pending
        req = 4'b0001;
        tick();
        expect_out("t6_lock", 4'b0001, 4'b1000, 8'hC4, 1'b0, 1'b1, 1'b0);
        pm[0] = 8'h41;
        req = 4'b0111;
        rst_n = 1'b0;
        tick();
        expect_out("t6_reset", 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_cnt", grant_cnt, '0);
        rst_n = 1'b1;
        tick();
        expect_out("t6_first", 4'b0001, 4'b0010, 8'h41, 1'b0, 1'b0, 1'b0);
        req = '0;
        tick();
        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && pgnt[i]) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                    else pm[i] = rnd_msg(i);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    pm[i] = rnd_msg(i);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        req = '0;
        tick();
        tick();
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
